reg_snapshot_tx: RTL

REG_SNAPSHOT_TX -- requirements
Module: reg_snapshot_tx

---
 rtl/reg_snapshot_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_snapshot_tx.sv
// Snapshot serialiser: latches {in1,in2} on request and sends it as a framed,
// parity-protected serial word (start, 5 data LSB-first, parity, stop).
module reg_snapshot_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in1,
  input  logic [3:0] in2,
  input  logic       snap_valid,
  output logic       snap_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   PRE_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic            ODD      = (PARITY_ODD != 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [4:0]    shadow;
  logic          bit_end;

  assign bit_end    = (cnt == LAST);
  assign snap_ready = (state == IDLE);

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      tx     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + CW'(1);

      case (state)
        IDLE: begin
          if (snap_valid) begin
            shadow <= {in1, in2};
            state  <= START;
            tx     <= 1'b0;
            busy   <= 1'b1;
            cnt    <= '0;
            idx    <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shadow[0];
            idx   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx == 3'd4) begin
              state <= PARITY;
              tx    <= (^shadow) ^ ODD;
            end else begin
              idx <= idx + 3'd1;
              tx  <= shadow[idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          // done is registered, so it is raised one cycle early to land on the final STOP cycle.
          if (cnt == PRE_LAST) done <= 1'b1;
          if (bit_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
